bios_code_mem: RTL and testbench
================================

# bios_code_mem

Parametrised, reloadable successor to the hardcoded BIOS instruction bank for the i281 multicycle CPU. Holds DEPTH instruction words of WIDTH bits (multicycle flag in the MSB) and serves them to the fetch unit through an asynchronous read port. After reset it rebuilds its boot image in hardware: a boot jump word at BOOT_ADDR and NOPs everywhere else. A valid/ready load port then lets the debug/loader front end overwrite any contiguous range at runtime, with range checking and a running checksum.

## Interface
- WIDTH, 17: instruction word width; bit WIDTH-1 is the multicycle flag.
- DEPTH, 16: number of words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH): address width, derived.
- BOOT_ADDR, 1: index that receives BOOT_WORD during init.
- BOOT_WORD, 17'h0E01E: boot word, JUMP with offset 30 and multicycle flag clear.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  ADDR_W  fetch address.
- rd_data  out  WIDTH  combinational word at rd_addr; forced to 0 (NOP) while busy.
- busy  out  1  high in INIT, LOAD and DONE; the CPU stalls fetch while high.
- ld_start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- ld_base  in  ADDR_W  first address of the load, sampled with ld_start.
- ld_count  in  ADDR_W+1  word count, 1..DEPTH, sampled with ld_start.
- ld_valid  in  1  ld_data holds a word.
- ld_data  in  WIDTH  word to write.
- ld_ready  out  1  high only in LOAD.
- ld_done  out  1  one-cycle pulse in DONE.
- ld_error  out  1  one-cycle pulse on a rejected ld_start.
- ld_csum  out  WIDTH  XOR of all words accepted in the current or last load.

## Operation
- States are INIT, IDLE, LOAD and DONE.
- INIT: an index counter i runs 0..DEPTH-1, writing one word per cycle: BOOT_WORD when i==BOOT_ADDR, otherwise 0. After i==DEPTH-1 is written, go to IDLE.
- IDLE: on ld_start, the request is checked.
  - Rejected if ld_count==0 or ld_base+ld_count>DEPTH, with the sum computed at ADDR_W+2 bits so it cannot wrap. A rejected request pulses ld_error next cycle, stays in IDLE and leaves memory and ld_csum unchanged.
  - Otherwise: latch wr_ptr=ld_base and remaining=ld_count, clear ld_csum, go to LOAD.
- LOAD: a word is accepted on a cycle where ld_valid && ld_ready. It is written to mem[wr_ptr], wr_ptr increments, remaining decrements, and ld_csum ^= ld_data. The acceptance with remaining==1 moves to DONE. ld_valid low simply stalls; there is no timeout.
- DONE: ld_done=1 for one cycle, then IDLE.
- ld_start outside IDLE is ignored: no error and no queuing.
- Writes happen only in INIT or on an accepted LOAD beat, never both in one cycle.
- Reset at any point, including mid-LOAD, discards the partial load and re-enters INIT. Memory is fully rebuilt.

## Timing
- Reset values: state=INIT, i=0, busy=1, ld_ready=0, ld_done=0, ld_error=0, ld_csum=0. rd_data=0 because busy is high.
- Init latency: the first edge with reset low writes word 0. busy is first low DEPTH cycles after reset deasserts (DEPTH=16 gives 16 cycles).
- Load latency: ld_start is seen on edge n, and ld_ready is high from cycle n+1. Counting from the first beat, with N words and no stalls, ld_done is high exactly N cycles later. busy drops the cycle after ld_done.
- ld_error is high the cycle after the rejected ld_start.
- Read path is combinational. A word written on edge n is visible on rd_data once busy is low, which is after DONE.
- ld_csum is registered and updates on the same edge as each accepted write.

## Structure
- Package bios_pkg holds:
  - the state enum;
  - the default WIDTH/DEPTH;
  - instruction field positions: MC flag 16, opcode 15:12, rx 11:10, ry 9:8, imm 7:0;
  - the BOOT_WORD constant and the OP_JUMP=4'b1110 constant.
- One sub-module, bios_ram: DEPTH×WIDTH array with one synchronous write port and one asynchronous read port. The FSM, counters and checksum live in bios_code_mem.

## Test plan
- Reset for 3 cycles, then release. busy must be high for exactly 16 cycles. Afterwards rd_addr=1 must give 17'h0E01E, and every other address must give 0.
- ld_start with base=4, count=3, data 17'h10001, 17'h00F0F, 17'h1FFFF and no stalls. Required: words land at 4..6, ld_done 3 cycles after the first beat, ld_csum=17'h0F0F1, and addresses 3 and 7 are untouched.
- Same load with ld_valid dropped for 2 cycles between beats. ld_ready must stay high, and ld_done must arrive 2 cycles later than in the no-stall case.
- ld_start with base=14, count=3 (overflow), then base=0, count=0. Each must give one ld_error pulse, with state, memory and ld_csum unchanged.
- Reset after 1 of 3 beats of a load. Required: busy high again for 16 cycles, then the boot image is restored (the partial word is gone) and ld_ready is 0.
- ld_start pulsed during INIT and during LOAD. It must be ignored: no error and no second load.

Source files
------------

// File: rtl/bios_pkg.sv
// Shared types and constants for the reloadable i281 BIOS instruction bank.
// Field positions describe the 17-bit i281 instruction word layout.
package bios_pkg;

  localparam int DEF_WIDTH = 17;
  localparam int DEF_DEPTH = 16;

  localparam int MC_BIT  = 16;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_JUMP = 4'b1110;

  // JUMP +30 with the multicycle flag clear: 17'h0E01E.
  localparam logic [DEF_WIDTH-1:0] BIOS_BOOT_WORD = {1'b0, OP_JUMP, 2'b00, 2'b00, 8'd30};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DEF_WIDTH-1:0] make_word(input logic       mc,
                                                     input logic [3:0] op,
                                                     input logic [1:0] rx,
                                                     input logic [1:0] ry,
                                                     input logic [7:0] imm);
    logic [DEF_WIDTH-1:0] w;
    w                   = '0;
    w[MC_BIT]           = mc;
    w[OP_MSB:OP_LSB]    = op;
    w[RX_MSB:RX_LSB]    = rx;
    w[RY_MSB:RY_LSB]    = ry;
    w[IMM_MSB:IMM_LSB]  = imm;
    return w;
  endfunction

endpackage

// File: rtl/bios_ram.sv
// DEPTH x WIDTH instruction array: one synchronous write port, one
// asynchronous read port feeding the fetch unit.
module bios_ram #(
  parameter int WIDTH  = 17,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bios_code_mem.sv
// Reloadable BIOS instruction bank: rebuilds the boot image after reset and
// accepts range-checked runtime loads with a running XOR checksum.
//
// Load handshake: a word moves on every rising edge where ld_valid && ld_ready;
// ld_ready is high for the whole LOAD state, and ld_valid low simply stalls.
module bios_code_mem
  import bios_pkg::*;
#(
  parameter int                 WIDTH     = DEF_WIDTH,
  parameter int                 DEPTH     = DEF_DEPTH,
  parameter int                 ADDR_W    = $clog2(DEPTH),
  parameter int                 BOOT_ADDR = 1,
  parameter logic [WIDTH-1:0]   BOOT_WORD = BIOS_BOOT_WORD
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_error,
  output logic [WIDTH-1:0]  ld_csum,
  output state_t            dbg_state
);

  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] BOOT_IDX  = ADDR_W'(BOOT_ADDR);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_remaining;
  logic [WIDTH-1:0]  r_csum;
  logic              r_ld_error;

  logic [ADDR_W+1:0] w_end;
  logic              w_reject;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [WIDTH-1:0]  w_wdata;
  logic [WIDTH-1:0]  w_rdata;

  // Two extra bits so base+count can never wrap past DEPTH.
  assign w_end      = {2'b00, ld_base} + {1'b0, ld_count};
  assign w_reject   = (ld_count == '0) || (w_end > DEPTH_EXT);
  assign w_start_ok = (r_state == ST_IDLE) && ld_start && !w_reject;
  assign w_accept   = (r_state == ST_LOAD) && ld_valid;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (r_idx == LAST_IDX) w_next_state = ST_IDLE;
      ST_IDLE: if (w_start_ok) w_next_state = ST_LOAD;
      ST_LOAD: if (w_accept && (r_remaining == (ADDR_W+1)'(1))) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_INIT;
    endcase
  end

  // INIT and LOAD are exclusive states, so the write port has one source per cycle.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = '0;
    if (r_state == ST_INIT) begin
      w_we    = 1'b1;
      w_wdata = (r_idx == BOOT_IDX) ? BOOT_WORD : '0;
    end else if (w_accept) begin
      w_we    = 1'b1;
      w_waddr = r_wr_ptr;
      w_wdata = ld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_csum      <= '0;
      r_ld_error  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_ld_error <= (r_state == ST_IDLE) && ld_start && w_reject;
      if (r_state == ST_INIT) begin
        r_idx <= r_idx + ADDR_W'(1);
      end
      if (w_start_ok) begin
        r_wr_ptr    <= ld_base;
        r_remaining <= ld_count;
        r_csum      <= '0;
      end
      if (w_accept) begin
        r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
        r_csum      <= r_csum ^ ld_data;
      end
    end
  end

  bios_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (w_rdata)
  );

  assign busy      = (r_state != ST_IDLE);
  assign ld_ready  = (r_state == ST_LOAD);
  assign ld_done   = (r_state == ST_DONE);
  assign ld_error  = r_ld_error;
  assign ld_csum   = r_csum;
  assign rd_data   = busy ? '0 : w_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bios_code_mem.sv
// Bench for bios_code_mem: behavioural memory/load model checked every cycle,
// plus directed boot, load, stall, reject, mid-load reset and ignore scenarios.
module tb_bios_code_mem;
  import bios_pkg::*;

  localparam int WIDTH = 17;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [WIDTH-1:0] BOOT = 17'h0E01E;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic [AW-1:0]    rd_addr  = '0;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             ld_start = 1'b0;
  logic [AW-1:0]    ld_base  = '0;
  logic [AW:0]      ld_count = '0;
  logic             ld_valid = 1'b0;
  logic [WIDTH-1:0] ld_data  = '0;
  logic             ld_ready;
  logic             ld_done;
  logic             ld_error;
  logic [WIDTH-1:0] ld_csum;
  state_t           dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  bios_code_mem dut (
    .clock     (clock),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_count  (ld_count),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_done   (ld_done),
    .ld_error  (ld_error),
    .ld_csum   (ld_csum),
    .dbg_state (dbg_state)
  );

  int errors     = 0;
  int checks     = 0;
  int cyc        = 0;
  int err_pulses = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] beat_q[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (ld_error === 1'b1) err_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_mem[DEPTH];
  int               m_init_left = 0;
  int               m_load_left = 0;
  int               m_ptr       = 0;
  bit               m_in_load   = 0;
  bit               m_done      = 0;
  bit               m_err       = 0;
  bit               m_was_done  = 0;
  bit               m_live      = 0;
  logic [WIDTH-1:0] m_csum      = '0;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = (i == 1) ? BOOT : '0;
      m_init_left = DEPTH;
      m_in_load   = 0;
      m_load_left = 0;
      m_done      = 0;
      m_err       = 0;
      m_csum      = '0;
      m_live      = 1;
    end else if (m_live) begin
      m_was_done = m_done;
      m_done     = 0;
      m_err      = 0;
      if (m_init_left > 0) begin
        m_init_left--;
      end else if (m_in_load) begin
        if (ld_valid) begin
          m_mem[m_ptr] = ld_data;
          m_ptr        = (m_ptr + 1) % DEPTH;
          m_csum       = m_csum ^ ld_data;
          m_load_left--;
          if (m_load_left == 0) begin
            m_in_load = 0;
            m_done    = 1;
          end
        end
      end else if (!m_was_done && ld_start) begin
        if (ld_count == 0 || int'(ld_base) + int'(ld_count) > DEPTH) begin
          m_err = 1;
        end else begin
          m_ptr       = int'(ld_base);
          m_load_left = int'(ld_count);
          m_csum      = '0;
          m_in_load   = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit               e_busy;
  logic [WIDTH-1:0] e_rd;
  always @(negedge clock) begin
    if (m_live) begin
      e_busy = (m_init_left > 0) || m_in_load || m_done;
      e_rd   = e_busy ? '0 : m_mem[rd_addr];
      check("busy",     busy,     e_busy);
      check("ld_ready", ld_ready, m_in_load);
      check("ld_done",  ld_done,  m_done);
      check("ld_error", ld_error, m_err);
      check("ld_csum",  ld_csum,  m_csum);
      check("rd_data",  rd_data,  e_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    rd_addr = 4'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic expect_init(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
    end
    check(name, n, DEPTH);
    tick();
  endtask

  task automatic read_range(input string name, input int base, input int count);
    for (int a = base; a < base + count; a++) begin
      rd_addr = 4'(a);
      #1;
      check(name, rd_data, exp_q.pop_front());
    end
  endtask

  task automatic expect_boot_image(input string name);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back((a == 1) ? BOOT : '0);
    read_range(name, 0, DEPTH);
  endtask

  // Runs a full load from beat_q; stall_len idle cycles precede beat stall_idx.
  task automatic run_load(input int base, input int count, input int stall_idx,
                          input int stall_len, input bit poke_start, output int lat);
    int first;
    int g;
    first    = -1;
    lat      = -1;
    ld_base  = 4'(base);
    ld_count = 5'(count);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < count; i++) begin
      if (i == stall_idx) begin
        repeat (stall_len) begin
          ld_valid = 1'b0;
          @(negedge clock);
          check("ready_during_stall", ld_ready, 1'b1);
          tick();
        end
      end
      g = 0;
      while (!ld_ready && g < 50) begin
        tick();
        g++;
      end
      if (g == 50) begin
        check("ready_timeout", 1'b0, 1'b1);
        break;
      end
      ld_valid = 1'b1;
      ld_data  = beat_q[i];
      if (poke_start && i == 1) begin
        ld_start = 1'b1;
        ld_base  = 4'd8;
        ld_count = 5'd1;
      end
      if (first < 0) first = cyc;
      tick();
      ld_start = 1'b0;
    end
    ld_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (ld_done) begin
        lat = cyc - first;
        break;
      end
    end
    tick();
  endtask

  task automatic reject_start(input string name, input int base, input int count);
    logic [WIDTH-1:0] csum_before;
    int               pulses_before;
    csum_before   = ld_csum;
    pulses_before = err_pulses;
    ld_base  = 4'(base);
    ld_count = 5'(count);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    @(negedge clock);
    check({name, "_error"}, ld_error, 1'b1);
    check({name, "_state"}, dbg_state, ST_IDLE);
    tick();
    tick();
    check({name, "_pulses"}, err_pulses - pulses_before, 1);
    check({name, "_csum"}, ld_csum, csum_before);
  endtask

  // ---------------- stimulus ----------------
  int               lat;
  int               base;
  int               count;
  int               sidx;
  int               slen;
  int               pulses0;
  logic [WIDTH-1:0] x;

  initial begin
    // Boot image after a 3-cycle reset.
    do_reset(3);
    rd_addr = 4'd1;
    #1;
    check("reset_busy",  busy,     1'b1);
    check("reset_ready", ld_ready, 1'b0);
    check("reset_done",  ld_done,  1'b0);
    check("reset_csum",  ld_csum,  '0);
    check("rd_while_busy", rd_data, '0);
    expect_init("init_busy_cycles");
    rd_addr = 4'd1;
    #1;
    check("boot_word", rd_data, 17'h0E01E);
    expect_boot_image("boot_image");

    // Unstalled load of 3 words at 4.
    beat_q = '{17'h10001, 17'h00F0F, 17'h1FFFF};
    run_load(4, 3, 99, 0, 0, lat);
    check("load_latency", lat, 3);
    check("load_csum", ld_csum, 17'h0F0F1);
    exp_q = '{17'h0, 17'h10001, 17'h00F0F, 17'h1FFFF, 17'h0};
    read_range("load_words", 3, 5);

    // Same load with a two-cycle stall before the second beat.
    run_load(4, 3, 1, 2, 0, lat);
    check("stall_latency", lat, 5);
    check("stall_csum", ld_csum, 17'h0F0F1);

    // Rejected requests.
    reject_start("overflow", 14, 3);
    reject_start("zero_count", 0, 0);
    exp_q = '{17'h0, 17'h10001};
    read_range("after_reject", 3, 2);

    // Boundary loads: range ending exactly at DEPTH, and a full-array load.
    beat_q = '{17'h0AAAA, 17'h15555, 17'h00123};
    run_load(13, 3, 99, 0, 0, lat);
    check("edge_latency", lat, 3);
    check("edge_csum", ld_csum, 17'h0AAAA ^ 17'h15555 ^ 17'h00123);
    beat_q.delete();
    x = '0;
    for (int i = 0; i < DEPTH; i++) begin
      beat_q.push_back(WIDTH'($urandom));
      x ^= beat_q[i];
    end
    run_load(0, DEPTH, 99, 0, 0, lat);
    check("full_latency", lat, DEPTH);
    check("full_csum", ld_csum, x);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(beat_q[i]);
    read_range("full_words", 0, DEPTH);

    // Randomized requests, valid and invalid.
    for (int it = 0; it < 10; it++) begin
      base  = $urandom_range(0, DEPTH - 1);
      count = $urandom_range(0, DEPTH + 1);
      if (count == 0 || base + count > DEPTH) begin
        reject_start("rand_reject", base, count);
      end else begin
        beat_q.delete();
        x = '0;
        for (int i = 0; i < count; i++) begin
          beat_q.push_back(WIDTH'($urandom));
          x ^= beat_q[i];
        end
        sidx = $urandom_range(0, count);
        slen = $urandom_range(0, 2);
        run_load(base, count, sidx, slen, 0, lat);
        check("rand_latency", lat, count + ((sidx >= 1 && sidx < count) ? slen : 0));
        check("rand_csum", ld_csum, x);
        for (int i = 0; i < count; i++) exp_q.push_back(beat_q[i]);
        read_range("rand_words", base, count);
      end
    end

    // Reset after one beat of a three-beat load.
    ld_base  = 4'd4;
    ld_count = 5'd3;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 17'h15555;
    tick();
    ld_valid = 1'b0;
    do_reset(1);
    expect_init("midload_reset_busy");
    check("midload_ready", ld_ready, 1'b0);
    check("midload_csum", ld_csum, '0);
    expect_boot_image("midload_image");

    // ld_start during INIT is ignored.
    do_reset(2);
    pulses0  = err_pulses;
    tick();
    ld_base  = 4'd0;
    ld_count = 5'd2;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    repeat (3) begin
      @(negedge clock);
      check("init_start_idle", busy, 1'b0);
      check("init_start_ready", ld_ready, 1'b0);
      tick();
    end
    check("init_start_no_error", err_pulses - pulses0, 0);
    expect_boot_image("init_start_image");

    // ld_start during LOAD is ignored.
    pulses0 = err_pulses;
    beat_q  = '{17'h00042, 17'h1C3C3};
    run_load(0, 2, 99, 0, 1, lat);
    check("load_start_latency", lat, 2);
    repeat (3) begin
      @(negedge clock);
      check("load_start_idle", busy, 1'b0);
      tick();
    end
    check("load_start_no_error", err_pulses - pulses0, 0);
    check("load_start_csum", ld_csum, 17'h00042 ^ 17'h1C3C3);
    exp_q = '{17'h0};
    read_range("load_start_addr8", 8, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
